// File: rtl/jpeg_row_packer_if.sv
// ---------------------------------------------------------------------------
// jpeg_row_packer_if
//
// Bundles the two valid/ready streams of the DCT input packer:
//   upstream   : in_data[31:0], in_valid, in_ready   (4 unsigned 8-bit pixels)
//   downstream : out_row[8*COEF_W-1:0], out_valid, out_ready, row_idx[2:0],
//                block_done
// Optional statistics (JPEG_PACKER_STATS_EN defined): blk_count[15:0],
// stall_count[15:0].
//
// Modports:
//   master : the environment side (DMA source and DCT sink)
//   slave  : the packer itself
// ---------------------------------------------------------------------------
interface jpeg_row_packer_if #(
  parameter int unsigned COEF_W = 12
);

  logic [31:0]         in_data;
  logic                in_valid;
  logic                in_ready;
  logic [8*COEF_W-1:0] out_row;
  logic                out_valid;
  logic                out_ready;
  logic [2:0]          row_idx;
  logic                block_done;

`ifdef JPEG_PACKER_STATS_EN
  logic [15:0]         blk_count;
  logic [15:0]         stall_count;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_row, out_valid, row_idx, block_done, blk_count, stall_count
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_row, out_valid, row_idx, block_done, blk_count, stall_count
  );
`else
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_row, out_valid, row_idx, block_done
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_row, out_valid, row_idx, block_done
  );
`endif

endinterface

// File: rtl/jpeg_row_packer.sv
// ---------------------------------------------------------------------------
// jpeg_row_packer
//
// Input stage of the 2-D DCT datapath. Takes 32-bit words of four unsigned
// luma pixels, level-shifts each by -128, sign-extends to COEF_W bits and
// pairs two words into one 8-lane row vector for the row 1-D DCT. Tracks the
// row position inside an 8x8 block and pulses block_done when the last row of
// a block has been taken downstream.
//
// Ports:
//   clk     : clock
//   rst     : synchronous, active-high reset
//   bus_io  : jpeg_row_packer_if.slave
//     in_data/in_valid/in_ready       upstream pixel words, bits[31:24] leftmost
//     out_row/out_valid/out_ready     row vector, lane k = column k (k=0 leftmost)
//     row_idx                         row number of the row on out_row
//     block_done                      one-cycle pulse after last row accepted
//
// Parameters:
//   COEF_W : lane width, signed two's complement, >= 9
//   ROWS   : rows per block (row_idx is 3 bits wide, so ROWS <= 8)
//
// Build option:
//   JPEG_PACKER_STATS_EN : adds blk_count (wrapping) and stall_count
//                          (saturating) statistics outputs.
// ---------------------------------------------------------------------------
module jpeg_row_packer #(
  parameter int unsigned COEF_W = 12,
  parameter int unsigned ROWS   = 8
) (
  input logic              clk,
  input logic              rst,
  jpeg_row_packer_if.slave bus_io
);

  localparam int unsigned HalfW   = 4 * COEF_W;
  localparam int unsigned RowW    = 8 * COEF_W;
  localparam logic [2:0]  LastRow = 3'(ROWS - 1);

  // Level shift of four pixels. p - 128 on an 8-bit unsigned value is just
  // the MSB inverted, read as two's complement; then sign-extend to COEF_W.
  // Lane 0 takes the leftmost pixel (bits[31:24]).
  function automatic logic [HalfW-1:0] level_shift(input logic [31:0] word);
    logic [HalfW-1:0] lanes;
    logic [7:0]       pix;
    logic [7:0]       shifted;
    lanes = '0;
    for (int k = 0; k < 4; k++) begin
      pix     = word[31-8*k -: 8];
      shifted = {~pix[7], pix[6:0]};
      lanes[COEF_W*k +: COEF_W] = {{(COEF_W-8){shifted[7]}}, shifted};
    end
    return lanes;
  endfunction

  typedef enum logic [0:0] {
    StLo,  // waiting for the first (left) word of a row
    StHi   // waiting for the second (right) word of a row
  } state_e;

  state_e state_q, state_d;

  logic [HalfW-1:0] hold_q, hold_d;
  logic [RowW-1:0]  row_q, row_d;
  logic             out_valid_q, out_valid_d;
  logic [2:0]       row_idx_q, row_idx_d;
  logic             block_done_q, block_done_d;

  logic             in_ready;
  logic             in_fire;
  logic             out_fire;
  logic             hold_load;
  logic             row_load;
  logic [HalfW-1:0] in_lanes;

  assign in_lanes = level_shift(bus_io.in_data);
  assign in_fire  = bus_io.in_valid & in_ready;
  assign out_fire = out_valid_q & bus_io.out_ready;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StLo;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLo: if (in_fire) state_d = StHi;
      StHi: if (in_fire) state_d = StLo;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // The left half is buffered in hold_q, so the first word can always be
  // taken. The second word needs the output register to be free, or to be
  // emptied by the downstream transfer in this same cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b1;
    hold_load = 1'b0;
    row_load  = 1'b0;
    unique case (state_q)
      StLo: begin
        in_ready  = 1'b1;
        hold_load = bus_io.in_valid;
      end
      StHi: begin
        in_ready = !out_valid_q || bus_io.out_ready;
        row_load = bus_io.in_valid && (!out_valid_q || bus_io.out_ready);
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath next state
  // -------------------------------------------------------------------------
  always_comb begin
    hold_d      = hold_q;
    row_d       = row_q;
    out_valid_d = out_valid_q;
    row_idx_d   = row_idx_q;

    if (hold_load) begin
      hold_d = in_lanes;
    end

    if (out_fire) begin
      out_valid_d = 1'b0;
      row_idx_d   = (row_idx_q == LastRow) ? 3'd0 : row_idx_q + 3'd1;
    end

    // A reload in the same cycle as a downstream transfer wins, so the new
    // row replaces the old one with no bubble.
    if (row_load) begin
      row_d       = {in_lanes, hold_q};
      out_valid_d = 1'b1;
    end

    block_done_d = out_fire && (row_idx_q == LastRow);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q       <= '0;
      row_q        <= '0;
      out_valid_q  <= 1'b0;
      row_idx_q    <= 3'd0;
      block_done_q <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      row_q        <= row_d;
      out_valid_q  <= out_valid_d;
      row_idx_q    <= row_idx_d;
      block_done_q <= block_done_d;
    end
  end

  assign bus_io.in_ready   = in_ready;
  assign bus_io.out_row    = row_q;
  assign bus_io.out_valid  = out_valid_q;
  assign bus_io.row_idx    = row_idx_q;
  assign bus_io.block_done = block_done_q;

`ifdef JPEG_PACKER_STATS_EN
  // -------------------------------------------------------------------------
  // Statistics: completed blocks (wrapping) and output stall cycles
  // (saturating).
  // -------------------------------------------------------------------------
  logic [15:0] blk_count_q, blk_count_d;
  logic [15:0] stall_count_q, stall_count_d;

  always_comb begin
    blk_count_d   = blk_count_q;
    stall_count_d = stall_count_q;
    if (block_done_q) begin
      blk_count_d = blk_count_q + 16'd1;
    end
    if (out_valid_q && !bus_io.out_ready && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_count_q   <= 16'd0;
      stall_count_q <= 16'd0;
    end else begin
      blk_count_q   <= blk_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus_io.blk_count   = blk_count_q;
  assign bus_io.stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_jpeg_row_packer.sv
module tb_jpeg_row_packer;

  localparam int unsigned CoefW = 12;
  localparam int unsigned Rows  = 8;
  localparam int unsigned RowW  = 8 * CoefW;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  jpeg_row_packer_if #(.COEF_W(CoefW)) bus ();

  jpeg_row_packer #(
    .COEF_W (CoefW),
    .ROWS   (Rows)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference conversion: arithmetic p - 128, truncated to the lane width.
  function automatic logic [CoefW-1:0] ref_pix(input logic [7:0] p);
    int v;
    v = int'(p) - 128;
    return v[CoefW-1:0];
  endfunction

  function automatic logic [RowW-1:0] ref_row(input logic [31:0] w0, input logic [31:0] w1);
    logic [63:0]     px;
    logic [RowW-1:0] r;
    px = {w0, w1};
    r  = '0;
    for (int k = 0; k < 8; k++) r[k*CoefW +: CoefW] = ref_pix(px[63-8*k -: 8]);
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Scoreboard: rows are predicted from accepted input words and checked
  // whenever out_valid is high; popped on each output transfer.
  // -------------------------------------------------------------------------
  typedef struct packed {
    logic [RowW-1:0] row;
    logic [2:0]      idx;
  } exp_t;

  exp_t        sb[$];
  exp_t        head;
  logic [31:0] m_hold;
  bit          m_half    = 1'b0;
  int          m_idx     = 0;
  bit          exp_bd    = 1'b0;
  int          mon_words = 0;
  int          mon_rows  = 0;
  int          mon_bd    = 0;

  always @(negedge clk) begin
    chk("block_done", {127'd0, bus.block_done}, {127'd0, exp_bd});
    if (bus.block_done === 1'b1) mon_bd++;
    if (rst) begin
      sb.delete();
      m_half = 1'b0;
      m_idx  = 0;
      exp_bd = 1'b0;
    end else begin
      exp_bd = 1'b0;
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", {127'd0, bus.out_valid}, 128'd0);
        end else begin
          head = sb[0];
          chk("row_data", {32'd0, bus.out_row}, {32'd0, head.row});
          chk("row_idx", {125'd0, bus.row_idx}, {125'd0, head.idx});
          if (bus.out_ready) begin
            void'(sb.pop_front());
            exp_bd = (int'(head.idx) == Rows - 1);
            mon_rows++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        mon_words++;
        if (!m_half) begin
          m_hold = bus.in_data;
          m_half = 1'b1;
        end else begin
          sb.push_back('{row: ref_row(m_hold, bus.in_data), idx: 3'(m_idx)});
          m_idx  = (m_idx + 1) % Rows;
          m_half = 1'b0;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Present a word and hold it until it is transferred; returns just after
  // the transfer edge with in_valid still high.
  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && n < 100) begin
      step();
      n++;
    end
    if (n == 100) chk("send_timeout", {127'd0, bus.in_ready}, 128'd1);
    step();
  endtask

  logic [31:0] w1, w2, w3, w4;
  int          pulses, r0, b0, wd0, cyc;
  bit          tog;

  initial begin
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    do_reset();
    chk("rst_out_valid", {127'd0, bus.out_valid}, 128'd0);
    chk("rst_out_row", {32'd0, bus.out_row}, 128'd0);
    chk("rst_row_idx", {125'd0, bus.row_idx}, 128'd0);
    chk("rst_block_done", {127'd0, bus.block_done}, 128'd0);
    chk("rst_in_ready", {127'd0, bus.in_ready}, 128'd1);

    // Known conversion values
    send_word(32'h0080FF01);
    send_word(32'h7F808080);
    bus.in_valid = 1'b0;
    chk("t1_out_valid", {127'd0, bus.out_valid}, 128'd1);
    chk("t1_out_row", {32'd0, bus.out_row}, {32'd0, 96'h000_000_000_FFF_F81_07F_000_F80});
    chk("t1_row_idx", {125'd0, bus.row_idx}, 128'd0);
    step();
    chk("t1_drained", {127'd0, bus.out_valid}, 128'd0);

    // Back-to-back block: one row every two cycles, one block_done pulse
    do_reset();
    bus.out_ready = 1'b1;
    r0 = mon_rows;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      bus.in_data  = $urandom;
      bus.in_valid = 1'b1;
      step();
      chk("t2_rate", {127'd0, bus.out_valid}, {127'd0, (i % 2) == 1});
      pulses += int'(bus.block_done);
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      pulses += int'(bus.block_done);
    end
    chk("t2_block_done_pulses", 128'(pulses), 128'd1);
    chk("t2_rows", 128'(mon_rows - r0), 128'd8);
    chk("t2_row_idx_wrap", {125'd0, bus.row_idx}, 128'd0);

    // Backpressure
    do_reset();
    bus.out_ready = 1'b0;
    w1 = $urandom; w2 = $urandom; w3 = $urandom; w4 = $urandom;
    send_word(w1);
    send_word(w2);
    chk("t3_in_ready_lo", {127'd0, bus.in_ready}, 128'd1);
    chk("t3_out_valid", {127'd0, bus.out_valid}, 128'd1);
    send_word(w3);
    bus.in_data = w4;
    chk("t3_in_ready_hi", {127'd0, bus.in_ready}, 128'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_stall_in_ready", {127'd0, bus.in_ready}, 128'd0);
      chk("t3_stall_row", {32'd0, bus.out_row}, {32'd0, ref_row(w1, w2)});
      chk("t3_stall_valid", {127'd0, bus.out_valid}, 128'd1);
    end
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("t3_reload_valid", {127'd0, bus.out_valid}, 128'd1);
    chk("t3_reload_row", {32'd0, bus.out_row}, {32'd0, ref_row(w3, w4)});
    chk("t3_reload_idx", {125'd0, bus.row_idx}, 128'd1);
    step();
    chk("t3_drained", {127'd0, bus.out_valid}, 128'd0);

    // Reset with a partial row held
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) send_word($urandom);
    bus.in_valid = 1'b0;
    step();
    chk("t4_row_idx_before", {125'd0, bus.row_idx}, 128'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t4_out_valid", {127'd0, bus.out_valid}, 128'd0);
    chk("t4_row_idx", {125'd0, bus.row_idx}, 128'd0);
    w1 = $urandom; w2 = $urandom;
    send_word(w1);
    send_word(w2);
    bus.in_valid = 1'b0;
    chk("t4_row", {32'd0, bus.out_row}, {32'd0, ref_row(w1, w2)});
    chk("t4_row0_idx", {125'd0, bus.row_idx}, 128'd0);
    chk("t4_row_valid", {127'd0, bus.out_valid}, 128'd1);
    step();

    // Sparse input with random backpressure over three blocks
    do_reset();
    wd0 = mon_words; r0 = mon_rows; b0 = mon_bd;
    cyc = 0; tog = 1'b0;
    while ((mon_words - wd0) < 48 && cyc < 3000) begin
      tog = ~tog;
      bus.in_valid  = tog;
      bus.in_data   = $urandom;
      bus.out_ready = 1'($urandom_range(0, 1));
      step();
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cyc = 0;
    while (sb.size() != 0 && cyc < 50) begin
      step();
      cyc++;
    end
    step();
    step();
    chk("t5_words", 128'(mon_words - wd0), 128'd48);
    chk("t5_rows", 128'(mon_rows - r0), 128'd24);
    chk("t5_blocks", 128'(mon_bd - b0), 128'd3);
    chk("t5_sb_empty", 128'(sb.size()), 128'd0);

`ifdef JPEG_PACKER_STATS_EN
    do_reset();
    chk("st_rst_blk", {112'd0, bus.blk_count}, 128'd0);
    chk("st_rst_stall", {112'd0, bus.stall_count}, 128'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.in_data  = $urandom;
      bus.in_valid = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    bus.out_ready = 1'b0;
    send_word($urandom);
    send_word($urandom);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("st_blk_count", {112'd0, bus.blk_count}, 128'd2);
    chk("st_stall_count", {112'd0, bus.stall_count}, 128'd5);
    for (int i = 0; i < 65540; i++) step();
    chk("st_stall_sat", {112'd0, bus.stall_count}, 128'hFFFF);
    bus.out_ready = 1'b1;
    step();
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
